// File: rtl/psram_port_arb_if.sv
// -----------------------------------------------------------------------------
// psram_port_arb_if
// Bundles every handshake/bus signal around the PSRAM port arbiter:
//   - two burst readers (r0_*, r1_*): read-address request plus routed data
//   - one burst writer (w_*): write-address request, urgency flag, beat strobe
//   - the shared controller port (m_*): read-address, read-data, write-address
//     and write-data-beat channels of psram_ctrl
// Modports:
//   slave  - the arbiter's view (takes requests and controller responses,
//            drives grants/acks toward requesters and requests toward psram_ctrl)
//   master - the environment's view (requesters plus psram_ctrl combined)
// Handshake rule: a request/address transfer happens in the cycle where both
// *valid and the matching *ready are 1; the requester holds address and valid
// steady until then. rvalid/wready beats are single-cycle strobes with no
// back-pressure.
// -----------------------------------------------------------------------------
interface psram_port_arb_if;
    // Reader 0 (HDMI2 frame reader)
    logic [24:0] r0_araddr;
    logic        r0_arvalid;
    logic        r0_arready;
    logic [17:0] r0_rdata;
    logic        r0_rvalid;
    // Reader 1 (RS232 capture dump)
    logic [24:0] r1_araddr;
    logic        r1_arvalid;
    logic        r1_arready;
    logic [17:0] r1_rdata;
    logic        r1_rvalid;
    // Writer (ADC capture FIFO drain)
    logic [24:0] w_awaddr;
    logic        w_awvalid;
    logic        w_urgent;
    logic        w_awready;
    logic        w_wready;
    // Shared psram_ctrl port
    logic [24:0] m_araddr;
    logic        m_arvalid;
    logic        m_arready;
    logic [17:0] m_rdata;
    logic        m_rvalid;
    logic [24:0] m_awaddr;
    logic        m_awvalid;
    logic        m_awready;
    logic        m_wready;

    modport slave (
        input  r0_araddr, r0_arvalid, r1_araddr, r1_arvalid,
        input  w_awaddr, w_awvalid, w_urgent,
        input  m_arready, m_rdata, m_rvalid, m_awready, m_wready,
        output r0_arready, r0_rdata, r0_rvalid,
        output r1_arready, r1_rdata, r1_rvalid,
        output w_awready, w_wready,
        output m_araddr, m_arvalid, m_awaddr, m_awvalid
    );

    modport master (
        output r0_araddr, r0_arvalid, r1_araddr, r1_arvalid,
        output w_awaddr, w_awvalid, w_urgent,
        output m_arready, m_rdata, m_rvalid, m_awready, m_wready,
        input  r0_arready, r0_rdata, r0_rvalid,
        input  r1_arready, r1_rdata, r1_rvalid,
        input  w_awready, w_wready,
        input  m_araddr, m_arvalid, m_awaddr, m_awvalid
    );
endinterface

// File: rtl/psram_port_arb.sv
// -----------------------------------------------------------------------------
// psram_port_arb
// Shares the single psram_ctrl port between two burst readers (R0, R1) and one
// burst writer (W). Exactly one transaction is in flight: IDLE -> ADDR -> DATA
// -> IDLE. An urgent writer wins outright, otherwise round-robin over
// {R0, R1, W} starting after the last grantee. Read data is broadcast, the read
// valid and write-beat strobe are routed to the owner only.
//
// Ports:
//   clk          48 MHz clock
//   reset_n      asynchronous active-low reset
//   psram_ready  controller init done; gates new grants only
//   bus          psram_port_arb_if.slave (requesters + controller channels)
//   err          sticky: timeout abort or stray m_rvalid; cleared by reset only
//   dbg_state    current FSM state (0 IDLE, 1 ADDR, 2 DATA)
//   stat_*       only with PSRAM_ARB_STATS_EN defined: saturating grant
//                counts and longest writer address wait
//
// Optional feature macro: PSRAM_ARB_STATS_EN
// -----------------------------------------------------------------------------
module psram_port_arb #(
    parameter int RD_BEATS = 4,
    parameter int WR_BEATS = 8,
    parameter int TMO      = 1023
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  psram_ready,
    psram_port_arb_if.slave       bus,
    output logic                  err,
    output logic [1:0]            dbg_state
`ifdef PSRAM_ARB_STATS_EN
    ,
    output logic [15:0]           stat_r0,
    output logic [15:0]           stat_r1,
    output logic [15:0]           stat_w,
    output logic [15:0]           stat_wmax
`endif
);

    localparam int TW = $clog2(TMO + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_R0 = 2'd0,
        OWN_R1 = 2'd1,
        OWN_W  = 2'd2
    } owner_t;

    state_t          r_state, w_state_nxt;
    owner_t          r_owner, w_owner_nxt;
    owner_t          r_rr,    w_rr_nxt;     // first candidate of the next round-robin scan
    logic [24:0]     r_addr,  w_addr_nxt;
    logic [3:0]      r_beat,  w_beat_nxt;
    logic [TW-1:0]   r_tmo,   w_tmo_nxt;
    logic            r_err,   w_err_nxt;

    owner_t          w_gnt;
    logic            w_gnt_vld;
    logic [24:0]     w_gnt_addr;
    logic            w_take;
    logic            w_rd_own;
    logic            w_addr_hs;
    logic            w_beat;
    logic [3:0]      w_last_beat;
    logic            w_stray;

    function automatic owner_t rr_after(input owner_t o);
        case (o)
            OWN_R0:  return OWN_R1;
            OWN_R1:  return OWN_W;
            default: return OWN_R0;
        endcase
    endfunction

    // Grant selection: urgent writer first, else scan starting at r_rr.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = OWN_R0;
        if (bus.w_urgent && bus.w_awvalid) begin
            w_gnt_vld = 1'b1;
            w_gnt     = OWN_W;
        end else begin
            case (r_rr)
                OWN_R1: begin
                    if (bus.r1_arvalid)      begin w_gnt_vld = 1'b1; w_gnt = OWN_R1; end
                    else if (bus.w_awvalid)  begin w_gnt_vld = 1'b1; w_gnt = OWN_W;  end
                    else if (bus.r0_arvalid) begin w_gnt_vld = 1'b1; w_gnt = OWN_R0; end
                end
                OWN_W: begin
                    if (bus.w_awvalid)       begin w_gnt_vld = 1'b1; w_gnt = OWN_W;  end
                    else if (bus.r0_arvalid) begin w_gnt_vld = 1'b1; w_gnt = OWN_R0; end
                    else if (bus.r1_arvalid) begin w_gnt_vld = 1'b1; w_gnt = OWN_R1; end
                end
                default: begin
                    if (bus.r0_arvalid)      begin w_gnt_vld = 1'b1; w_gnt = OWN_R0; end
                    else if (bus.r1_arvalid) begin w_gnt_vld = 1'b1; w_gnt = OWN_R1; end
                    else if (bus.w_awvalid)  begin w_gnt_vld = 1'b1; w_gnt = OWN_W;  end
                end
            endcase
        end
    end

    always_comb begin
        case (w_gnt)
            OWN_R1:  w_gnt_addr = bus.r1_araddr;
            OWN_W:   w_gnt_addr = bus.w_awaddr;
            default: w_gnt_addr = bus.r0_araddr;
        endcase
    end

    assign w_take      = (r_state == ST_IDLE) && psram_ready && w_gnt_vld;
    assign w_rd_own    = (r_owner != OWN_W);
    assign w_addr_hs   = (r_state == ST_ADDR) && (w_rd_own ? bus.m_arready : bus.m_awready);
    assign w_beat      = (r_state == ST_DATA) && (w_rd_own ? bus.m_rvalid : bus.m_wready);
    assign w_last_beat = w_rd_own ? 4'(RD_BEATS - 1) : 4'(WR_BEATS - 1);
    // Any read beat not belonging to a read DATA phase is swallowed and flagged.
    assign w_stray     = bus.m_rvalid && !((r_state == ST_DATA) && w_rd_own);

    // Next-state logic. The timeout counter counts cycles without a handshake
    // or beat; the TMO-th such cycle aborts the transaction back to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr;
        w_addr_nxt  = r_addr;
        w_beat_nxt  = r_beat;
        w_tmo_nxt   = r_tmo;
        w_err_nxt   = r_err;

        case (r_state)
            ST_IDLE: begin
                w_tmo_nxt  = '0;
                w_beat_nxt = '0;
                if (w_take) begin
                    w_state_nxt = ST_ADDR;
                    w_owner_nxt = w_gnt;
                    w_rr_nxt    = rr_after(w_gnt);
                    w_addr_nxt  = w_gnt_addr;
                end
            end
            ST_ADDR: begin
                if (w_addr_hs) begin
                    w_state_nxt = ST_DATA;
                    w_tmo_nxt   = '0;
                    w_beat_nxt  = '0;
                end else if (r_tmo == TW'(TMO - 1)) begin
                    w_state_nxt = ST_IDLE;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_tmo_nxt = r_tmo + 1'b1;
                end
            end
            ST_DATA: begin
                if (w_beat) begin
                    w_tmo_nxt = '0;
                    if (r_beat == w_last_beat) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_beat_nxt = r_beat + 1'b1;
                    end
                end else if (r_tmo == TW'(TMO - 1)) begin
                    w_state_nxt = ST_IDLE;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_tmo_nxt = r_tmo + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_stray) begin
            w_err_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_owner <= OWN_R0;
            r_rr    <= OWN_R0;
            r_addr  <= '0;
            r_beat  <= '0;
            r_tmo   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_rr    <= w_rr_nxt;
            r_addr  <= w_addr_nxt;
            r_beat  <= w_beat_nxt;
            r_tmo   <= w_tmo_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Controller-side requests come straight from registered state, so the
    // first valid appears the cycle after a grant.
    assign bus.m_arvalid  = (r_state == ST_ADDR) && w_rd_own;
    assign bus.m_awvalid  = (r_state == ST_ADDR) && !w_rd_own;
    assign bus.m_araddr   = r_addr;
    assign bus.m_awaddr   = r_addr;

    // Acks pulse in the controller handshake cycle.
    assign bus.r0_arready = (r_state == ST_ADDR) && (r_owner == OWN_R0) && bus.m_arready;
    assign bus.r1_arready = (r_state == ST_ADDR) && (r_owner == OWN_R1) && bus.m_arready;
    assign bus.w_awready  = (r_state == ST_ADDR) && (r_owner == OWN_W)  && bus.m_awready;

    assign bus.r0_rvalid  = (r_state == ST_DATA) && (r_owner == OWN_R0) && bus.m_rvalid;
    assign bus.r1_rvalid  = (r_state == ST_DATA) && (r_owner == OWN_R1) && bus.m_rvalid;
    assign bus.w_wready   = (r_state == ST_DATA) && (r_owner == OWN_W)  && bus.m_wready;

    // Read data is broadcast; gated by reset so every output reads 0 in reset.
    assign bus.r0_rdata   = reset_n ? bus.m_rdata : '0;
    assign bus.r1_rdata   = reset_n ? bus.m_rdata : '0;

    assign err       = r_err;
    assign dbg_state = r_state;

`ifdef PSRAM_ARB_STATS_EN
    logic [15:0] r_stat_r0, r_stat_r1, r_stat_w, r_stat_wmax, r_wwait;

    // r_wwait counts cycles the writer held awvalid before its awready cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stat_r0   <= '0;
            r_stat_r1   <= '0;
            r_stat_w    <= '0;
            r_stat_wmax <= '0;
            r_wwait     <= '0;
        end else begin
            if (w_take) begin
                case (w_gnt)
                    OWN_R0:  if (r_stat_r0 != 16'hFFFF) r_stat_r0 <= r_stat_r0 + 16'd1;
                    OWN_R1:  if (r_stat_r1 != 16'hFFFF) r_stat_r1 <= r_stat_r1 + 16'd1;
                    default: if (r_stat_w  != 16'hFFFF) r_stat_w  <= r_stat_w  + 16'd1;
                endcase
            end
            if (bus.w_awready) begin
                if (r_wwait > r_stat_wmax) begin
                    r_stat_wmax <= r_wwait;
                end
                r_wwait <= '0;
            end else if (bus.w_awvalid) begin
                if (r_wwait != 16'hFFFF) begin
                    r_wwait <= r_wwait + 16'd1;
                end
            end else begin
                r_wwait <= '0;
            end
        end
    end

    assign stat_r0   = r_stat_r0;
    assign stat_r1   = r_stat_r1;
    assign stat_w    = r_stat_w;
    assign stat_wmax = r_stat_wmax;
`endif

endmodule

// File: tb/tb_psram_port_arb.sv
// -----------------------------------------------------------------------------
// tb_psram_port_arb
// Directed bench for psram_port_arb. The stimulus process plays requesters and
// psram_ctrl, pushing expected grants {owner, address} into exp_q and direct
// expectations into chk_q; the monitor process pops and compares both on the
// falling clock edge.
// -----------------------------------------------------------------------------
module tb_psram_port_arb;

    localparam int RD_BEATS = 4;
    localparam int WR_BEATS = 8;
    localparam int TMO      = 1023;

    localparam logic [24:0] A_R0 = 25'h0001000;
    localparam logic [24:0] A_R1 = 25'h0ABCDE0;
    localparam logic [24:0] A_W  = 25'h1F00F00;

    localparam logic [1:0] O_R0 = 2'd0;
    localparam logic [1:0] O_R1 = 2'd1;
    localparam logic [1:0] O_W  = 2'd2;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n;
    logic psram_ready;
    logic err;
    logic [1:0] dbg_state;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    psram_port_arb_if bus ();

`ifdef PSRAM_ARB_STATS_EN
    logic [15:0] stat_r0, stat_r1, stat_w, stat_wmax;
`endif

    psram_port_arb #(
        .RD_BEATS (RD_BEATS),
        .WR_BEATS (WR_BEATS),
        .TMO      (TMO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .psram_ready (psram_ready),
        .bus         (bus.slave),
        .err         (err),
        .dbg_state   (dbg_state)
`ifdef PSRAM_ARB_STATS_EN
        ,
        .stat_r0     (stat_r0),
        .stat_r1     (stat_r1),
        .stat_w      (stat_w),
        .stat_wmax   (stat_wmax)
`endif
    );

    // ---------------- scoreboard ----------------
    logic [26:0] exp_q[$];
    chk_t        chk_q[$];
    int          n_total = 0;
    int          n_pass  = 0;
    int          n_r0_beats = 0;
    int          n_r1_beats = 0;
    int          n_w_beats  = 0;
    int          last_wbeat_cyc = 0;
    int          ar_rise_cyc = 0;

    function automatic void push_chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.act  = act;
        c.exp  = exp;
        chk_q.push_back(c);
    endfunction

    initial begin : monitor
        logic [1:0]  own;
        logic [26:0] act_g;
        logic [26:0] exp_g;
        logic        prev_arvalid;
        chk_t        c;
        prev_arvalid = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_n && ((bus.m_arvalid && bus.m_arready) || (bus.m_awvalid && bus.m_awready))) begin
                own = bus.r0_arready ? O_R0 : bus.r1_arready ? O_R1 : bus.w_awready ? O_W : 2'd3;
                act_g = {own, (bus.m_arvalid ? bus.m_araddr : bus.m_awaddr)};
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL grant: got %0h, no grant expected", act_g);
                end else begin
                    exp_g = exp_q.pop_front();
                    if (act_g == exp_g) n_pass++;
                    else $display("FAIL grant: got %0h expected %0h", act_g, exp_g);
                end
            end
            if (bus.r0_rvalid) n_r0_beats++;
            if (bus.r1_rvalid) n_r1_beats++;
            if (bus.w_wready) begin
                n_w_beats++;
                last_wbeat_cyc = cyc;
            end
            if (bus.m_arvalid && !prev_arvalid) ar_rise_cyc = cyc;
            prev_arvalid = bus.m_arvalid;
            while (chk_q.size() > 0) begin
                c = chk_q.pop_front();
                n_total++;
                if (c.act === c.exp) n_pass++;
                else $display("FAIL %s: got %0h expected %0h", c.name, c.act, c.exp);
            end
        end
    end

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    // Acts as psram_ctrl: waits for an address request, acks it for one cycle,
    // then streams rd_n read beats or wr_n write beats back to back.
    // drop_mask clears requester valids {w, r1, r0} right after the handshake.
    task automatic serve_any(input int rd_n, input int wr_n, input logic [2:0] drop_mask);
        int wait_cyc;
        bit found;
        bit is_rd;
        found    = 1'b0;
        is_rd    = 1'b0;
        wait_cyc = 0;
        while (!found && wait_cyc < 50) begin
            @(posedge clk); #1;
            if (bus.m_arvalid) begin
                found = 1'b1;
                is_rd = 1'b1;
            end else if (bus.m_awvalid) begin
                found = 1'b1;
                is_rd = 1'b0;
            end
            wait_cyc++;
        end
        push_chk("serve_addr_valid_seen", 32'(found), 32'd1);
        if (!found) return;
        if (is_rd) bus.m_arready = 1'b1;
        else       bus.m_awready = 1'b1;
        @(posedge clk); #1;
        bus.m_arready = 1'b0;
        bus.m_awready = 1'b0;
        if (drop_mask[0]) bus.r0_arvalid = 1'b0;
        if (drop_mask[1]) bus.r1_arvalid = 1'b0;
        if (drop_mask[2]) begin
            bus.w_awvalid = 1'b0;
            bus.w_urgent  = 1'b0;
        end
        for (int i = 0; i < (is_rd ? rd_n : wr_n); i++) begin
            if (is_rd) begin
                bus.m_rvalid = 1'b1;
                bus.m_rdata  = 18'(i + 1);
            end else begin
                bus.m_wready = 1'b1;
            end
            @(posedge clk); #1;
        end
        bus.m_rvalid = 1'b0;
        bus.m_wready = 1'b0;
        bus.m_rdata  = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    int  b_r0, b_r1, b_w;
    bit  bad;

    initial begin : stimulus
        reset_n        = 1'b0;
        psram_ready    = 1'b0;
        bus.r0_araddr  = A_R0;
        bus.r0_arvalid = 1'b0;
        bus.r1_araddr  = A_R1;
        bus.r1_arvalid = 1'b0;
        bus.w_awaddr   = A_W;
        bus.w_awvalid  = 1'b0;
        bus.w_urgent   = 1'b0;
        bus.m_arready  = 1'b0;
        bus.m_rdata    = '0;
        bus.m_rvalid   = 1'b0;
        bus.m_awready  = 1'b0;
        bus.m_wready   = 1'b0;
        #2;
        push_chk("reset_state", 32'(dbg_state), 32'd0);
        push_chk("reset_err", 32'(err), 32'd0);
        do_reset();

        // 1: no grants while psram_ready=0, then one-cycle latency
        bus.r0_arvalid = 1'b1;
        bus.r1_arvalid = 1'b1;
        bus.w_awvalid  = 1'b1;
        bad = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (bus.m_arvalid || bus.m_awvalid || bus.r0_arready || bus.r1_arready || bus.w_awready)
                bad = 1'b1;
        end
        push_chk("t1_no_grant_not_ready", 32'(bad), 32'd0);
        b_r0 = n_r0_beats; b_r1 = n_r1_beats; b_w = n_w_beats;
        exp_q.push_back({O_R0, A_R0});
        exp_q.push_back({O_R1, A_R1});
        exp_q.push_back({O_W,  A_W});
        exp_q.push_back({O_R0, A_R0});
        exp_q.push_back({O_R1, A_R1});
        exp_q.push_back({O_W,  A_W});
        @(posedge clk); #1;
        psram_ready = 1'b1;
        @(negedge clk);
        push_chk("t1_arvalid_same_cycle", 32'(bus.m_arvalid), 32'd0);
        @(negedge clk);
        push_chk("t1_arvalid_next_cycle", 32'(bus.m_arvalid), 32'd1);

        // 2: round robin R0,R1,W,R0,R1,W with full bursts
        repeat (5) serve_any(RD_BEATS, WR_BEATS, 3'b000);
        serve_any(RD_BEATS, WR_BEATS, 3'b111);
        @(negedge clk);
        push_chk("t2_r0_beats", 32'(n_r0_beats - b_r0), 32'd8);
        push_chk("t2_r1_beats", 32'(n_r1_beats - b_r1), 32'd8);
        push_chk("t2_w_beats",  32'(n_w_beats - b_w),   32'd16);
        push_chk("t2_err", 32'(err), 32'd0);

        // 3: urgent writer beats R0 although round robin points at R0
        @(posedge clk); #1;
        b_r0 = n_r0_beats; b_w = n_w_beats;
        exp_q.push_back({O_W,  A_W});
        exp_q.push_back({O_R0, A_R0});
        bus.r0_arvalid = 1'b1;
        bus.w_awvalid  = 1'b1;
        bus.w_urgent   = 1'b1;
        serve_any(RD_BEATS, WR_BEATS, 3'b100);
        serve_any(RD_BEATS, WR_BEATS, 3'b001);
        @(negedge clk);
        push_chk("t3_gap_wbeat8_to_arvalid", 32'(ar_rise_cyc - last_wbeat_cyc), 32'd2);
        push_chk("t3_r0_beats", 32'(n_r0_beats - b_r0), 32'd4);
        push_chk("t3_w_beats",  32'(n_w_beats - b_w),   32'd8);

        // 4: stray m_rvalid while IDLE
        push_chk("t4_err_before", 32'(err), 32'd0);
        @(posedge clk); #1;
        bus.m_rvalid = 1'b1;
        bus.m_rdata  = 18'h155;
        @(negedge clk);
        push_chk("t4_r0_rvalid_blocked", 32'(bus.r0_rvalid), 32'd0);
        push_chk("t4_r1_rvalid_blocked", 32'(bus.r1_rvalid), 32'd0);
        @(posedge clk); #1;
        bus.m_rvalid = 1'b0;
        bus.m_rdata  = '0;
        push_chk("t4_err_set", 32'(err), 32'd1);
        repeat (10) @(posedge clk);
        #1 push_chk("t4_err_sticky", 32'(err), 32'd1);
        do_reset();
        push_chk("t4_err_cleared_by_reset", 32'(err), 32'd0);

        // 5: stall after 2 beats -> timeout abort, then normal grant
        exp_q.push_back({O_R0, A_R0});
        bus.r0_arvalid = 1'b1;
        serve_any(2, WR_BEATS, 3'b001);
        repeat (1020) @(posedge clk);
        #1;
        push_chk("t5_still_data_before_tmo", 32'(dbg_state), 32'd2);
        push_chk("t5_err_before_tmo", 32'(err), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        push_chk("t5_idle_after_tmo", 32'(dbg_state), 32'd0);
        push_chk("t5_err_after_tmo", 32'(err), 32'd1);
        b_r1 = n_r1_beats;
        exp_q.push_back({O_R1, A_R1});
        bus.r1_arvalid = 1'b1;
        serve_any(RD_BEATS, WR_BEATS, 3'b010);
        @(negedge clk);
        push_chk("t5_r1_beats", 32'(n_r1_beats - b_r1), 32'd4);
        push_chk("t5_back_idle", 32'(dbg_state), 32'd0);

        // 6: reset during write beat 3, then R0 preferred
        @(posedge clk); #1;
        exp_q.push_back({O_W, A_W});
        bus.w_awvalid = 1'b1;
        serve_any(RD_BEATS, 2, 3'b100);
        bus.m_wready = 1'b1;
        bus.m_rdata  = 18'h2AAAA;
        #1;
        push_chk("t6_beat3_wready", 32'(bus.w_wready), 32'd1);
        push_chk("t6_rdata_broadcast", 32'(bus.r1_rdata), 32'h2AAAA);
        #1 reset_n = 1'b0;
        #1;
        push_chk("t6_rst_wready", 32'(bus.w_wready), 32'd0);
        push_chk("t6_rst_awvalid", 32'(bus.m_awvalid), 32'd0);
        push_chk("t6_rst_rdata", 32'(bus.r0_rdata), 32'd0);
        push_chk("t6_rst_err", 32'(err), 32'd0);
        push_chk("t6_rst_state", 32'(dbg_state), 32'd0);
        bus.m_wready = 1'b0;
        bus.m_rdata  = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        exp_q.push_back({O_R0, A_R0});
        bus.r0_arvalid = 1'b1;
        bus.r1_arvalid = 1'b1;
        bus.w_awvalid  = 1'b1;
        serve_any(RD_BEATS, WR_BEATS, 3'b111);
        @(negedge clk);
        push_chk("t6_err_end", 32'(err), 32'd0);
        push_chk("t6_idle_end", 32'(dbg_state), 32'd0);

        repeat (3) @(negedge clk);
        push_chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
